// File: rtl/axi_pkg.sv
// Shared AXI read-channel definitions: response codes, the AR FSM state type
// and a helper that classifies R responses as errors.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {AR_IDLE, AR_SEND} ar_fsm_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// Bundles the cache-side request/response handshake and the AXI4-Lite AR/R
// channels. The master modport is the read master's view.
interface axi_rd_master_if;

  logic        axi_rd_rq;
  logic [31:0] axi_rd_addr;
  logic        axi_rd_rq_ack;
  logic [31:0] axi_rd_data;
  logic        axi_rd_valid;
  logic        axi_rd_err;
  logic        axi_rd_valid_ack;

  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic        m_arid;
  logic [2:0]  m_arprot;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  modport master (
    input  axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
           m_arready, m_rvalid, m_rdata, m_rresp,
    output axi_rd_rq_ack, axi_rd_data, axi_rd_valid, axi_rd_err,
           m_arvalid, m_araddr, m_arid, m_arprot, m_rready
  );

  modport slave (
    output axi_rd_rq, axi_rd_addr, axi_rd_valid_ack,
           m_arready, m_rvalid, m_rdata, m_rresp,
    input  axi_rd_rq_ack, axi_rd_data, axi_rd_valid, axi_rd_err,
           m_arvalid, m_araddr, m_arid, m_arprot, m_rready
  );

endinterface

// File: rtl/axi_req_fifo.sv
// Synchronous request FIFO with registered storage and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axi_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_data  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4-Lite read master: buffers cache miss requests, issues them in order on
// AR with a bounded number outstanding, and hands R data back to the cache.
module axi_rd_master
  import axi_pkg::*;
#(
  parameter int   REQ_DEPTH       = 4,
  parameter int   MAX_OUTSTANDING = 2,
  parameter logic AXI_ID          = 1'b0
) (
  input  logic            axi_clk,
  input  logic            i_rst,
  axi_rd_master_if.master bus,
  output logic            unexp_r_err
);

  localparam int              CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_OUTSTANDING);

  ar_fsm_t       r_state;
  logic          r_arvalid;
  logic [31:0]   r_araddr;
  logic [CW-1:0] r_outCnt;
  logic          r_rdValid;
  logic [31:0]   r_rdData;
  logic          r_rdErr;
  logic          r_unexp;

  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_fifoData;
  logic [31:0]   w_reqAddr;
  logic          w_push;
  logic          w_pop;
  logic          w_arHs;
  logic          w_rHs;

  assign w_reqAddr = bus.axi_rd_addr & 32'hFFFF_FFFC;
  assign w_push    = bus.axi_rd_rq && !w_full;
  assign w_pop     = (r_state == AR_IDLE) && !w_empty && (r_outCnt < MAX_C);
  assign w_arHs    = r_arvalid && bus.m_arready;
  assign w_rHs     = bus.m_rvalid && !r_rdValid;

  assign bus.axi_rd_rq_ack = !w_full;
  assign bus.m_arvalid     = r_arvalid;
  assign bus.m_araddr      = r_araddr;
  assign bus.m_arid        = AXI_ID;
  assign bus.m_arprot      = 3'b000;
  assign bus.m_rready      = !r_rdValid;
  assign bus.axi_rd_valid  = r_rdValid;
  assign bus.axi_rd_data   = r_rdData;
  assign bus.axi_rd_err    = r_rdErr;
  assign unexp_r_err       = r_unexp;

  axi_req_fifo #(
    .WIDTH (32),
    .DEPTH (REQ_DEPTH)
  ) u_reqFifo (
    .clk     (axi_clk),
    .rst     (i_rst),
    .i_push  (w_push),
    .i_data  (w_reqAddr),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= AR_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
    end else begin
      case (r_state)
        AR_IDLE: begin
          if (w_pop) begin
            r_araddr  <= w_fifoData;
            r_arvalid <= 1'b1;
            r_state   <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (bus.m_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= AR_IDLE;
          end
        end
        default: r_state <= AR_IDLE;
      endcase
    end
  end

  // A beat with nothing outstanding is flagged but never decrements below zero.
  always_ff @(posedge axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outCnt <= '0;
    end else begin
      if (w_arHs && !(w_rHs && r_outCnt != '0)) begin
        r_outCnt <= r_outCnt + CW'(1);
      end else if (!w_arHs && w_rHs && r_outCnt != '0) begin
        r_outCnt <= r_outCnt - CW'(1);
      end
    end
  end

  always_ff @(posedge axi_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
      r_rdErr   <= 1'b0;
      r_unexp   <= 1'b0;
    end else begin
      if (w_rHs) begin
        r_rdValid <= 1'b1;
        r_rdData  <= bus.m_rdata;
        r_rdErr   <= resp_is_err(bus.m_rresp);
        if (r_outCnt == '0) r_unexp <= 1'b1;
      end else if (r_rdValid && bus.axi_rd_valid_ack) begin
        r_rdValid <= 1'b0;
      end
    end
  end

endmodule
